// File: rtl/fft16_pkg.sv
// Shared definitions for the sequential 16-point radix-4 FFT: FSM states,
// sizes, Q1.15 twiddle constants and small fixed-point helpers.
package fft16_pkg;

  localparam int N   = 16;
  localparam int RAD = 4;

  typedef enum logic [1:0] {LOAD, STAGE0, STAGE1, UNLOAD} state_t;

  // W16^m = cos(2*pi*m/16) - j*sin(2*pi*m/16) in Q1.15
  localparam logic signed [15:0] W0_RE = 16'sd32767;
  localparam logic signed [15:0] W0_IM = 16'sd0;
  localparam logic signed [15:0] W1_RE = 16'sd30274;
  localparam logic signed [15:0] W1_IM = -16'sd12540;
  localparam logic signed [15:0] W2_RE = 16'sd23170;
  localparam logic signed [15:0] W2_IM = -16'sd23170;
  localparam logic signed [15:0] W3_RE = 16'sd12540;
  localparam logic signed [15:0] W3_IM = -16'sd30274;
  localparam logic signed [15:0] W4_RE = 16'sd0;
  localparam logic signed [15:0] W4_IM = -16'sd32767;
  localparam logic signed [15:0] W6_RE = -16'sd23170;
  localparam logic signed [15:0] W6_IM = -16'sd23170;
  localparam logic signed [15:0] W9_RE = -16'sd30274;
  localparam logic signed [15:0] W9_IM = 16'sd12540;

  function automatic logic [3:0] tw_index(logic [1:0] n0, logic [1:0] k1);
    return 4'(n0) * 4'(k1);
  endfunction

  // Returns {re, im}; only the exponents reachable from n0*k1 are listed.
  function automatic logic [31:0] twiddle(logic [3:0] m);
    case (m)
      4'd1:    return {W1_RE, W1_IM};
      4'd2:    return {W2_RE, W2_IM};
      4'd3:    return {W3_RE, W3_IM};
      4'd4:    return {W4_RE, W4_IM};
      4'd6:    return {W6_RE, W6_IM};
      4'd9:    return {W9_RE, W9_IM};
      default: return {W0_RE, W0_IM};
    endcase
  endfunction

  function automatic logic signed [15:0] half_sat(logic signed [17:0] v);
    logic signed [17:0] h;
    h = v >>> 1;
    if (h > 18'sd32767)       return 16'sh7fff;
    else if (h < -18'sd32768) return 16'sh8000;
    else                      return 16'(h);
  endfunction

endpackage

// File: rtl/fft16_r4_seq_bfly.sv
// Radix-4 forward butterfly on four Q1.15 complex lanes, every output halved.
// Lane j occupies bits [16*j +: 16] of each packed bus.
module r4_bfly
  import fft16_pkg::*;
(
  input  logic [63:0] x_re,
  input  logic [63:0] x_im,
  output logic [63:0] y_re,
  output logic [63:0] y_im
);

  logic signed [17:0] xr [RAD];
  logic signed [17:0] xi [RAD];
  logic signed [17:0] sr [RAD];
  logic signed [17:0] si [RAD];

  always_comb begin
    for (int j = 0; j < RAD; j++) begin
      xr[j] = 18'($signed(x_re[16*j +: 16]));
      xi[j] = 18'($signed(x_im[16*j +: 16]));
    end
    // y1 = a - jb - c + jd, y3 = a + jb - c - jd
    sr[0] = xr[0] + xr[1] + xr[2] + xr[3];
    si[0] = xi[0] + xi[1] + xi[2] + xi[3];
    sr[1] = xr[0] + xi[1] - xr[2] - xi[3];
    si[1] = xi[0] - xr[1] - xi[2] + xr[3];
    sr[2] = xr[0] - xr[1] + xr[2] - xr[3];
    si[2] = xi[0] - xi[1] + xi[2] - xi[3];
    sr[3] = xr[0] - xi[1] - xr[2] + xi[3];
    si[3] = xi[0] + xr[1] - xi[2] - xr[3];
    for (int j = 0; j < RAD; j++) begin
      y_re[16*j +: 16] = half_sat(sr[j]);
      y_im[16*j +: 16] = half_sat(si[j]);
    end
  end

endmodule

// File: rtl/fft16_r4_seq_cmul.sv
// Q1.15 complex multiply: full products, round half up, arithmetic shift,
// saturate; sat reports that either component was clamped.
module cmul_q15 #(
  parameter int FRAC = 15
) (
  input  logic signed [15:0] xr,
  input  logic signed [15:0] xi,
  input  logic signed [15:0] wr,
  input  logic signed [15:0] wi,
  output logic signed [15:0] yr,
  output logic signed [15:0] yi,
  output logic               sat
);

  localparam logic signed [32:0] RND = 33'sd1 <<< (FRAC - 1);

  logic signed [31:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [32:0] acc_re, acc_im, sh_re, sh_im;
  logic               clip_re, clip_im;

  always_comb begin
    p_rr    = xr * wr;
    p_ii    = xi * wi;
    p_ri    = xr * wi;
    p_ir    = xi * wr;
    acc_re  = 33'(p_rr) - 33'(p_ii) + RND;
    acc_im  = 33'(p_ri) + 33'(p_ir) + RND;
    sh_re   = acc_re >>> FRAC;
    sh_im   = acc_im >>> FRAC;
    clip_re = (sh_re > 33'sd32767) || (sh_re < -33'sd32768);
    clip_im = (sh_im > 33'sd32767) || (sh_im < -33'sd32768);
    yr      = clip_re ? (sh_re[32] ? 16'sh8000 : 16'sh7fff) : sh_re[15:0];
    yi      = clip_im ? (sh_im[32] ? 16'sh8000 : 16'sh7fff) : sh_im[15:0];
    sat     = clip_re | clip_im;
  end

endmodule

// File: rtl/fft16_r4_seq.sv
// Sequential 16-point forward DIF FFT: one shared radix-4 butterfly run over an
// in-place buffer in two stages. Optional sticky clamp flag: FFT16_SAT_FLAG_EN.
module fft16_r4_seq
  import fft16_pkg::*;
#(
  parameter int DW      = 16,
  parameter int TW_FRAC = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_real,
  input  logic signed [DW-1:0] in_imag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_real,
  output logic signed [DW-1:0] out_imag,
  output logic                 out_last,
  output logic                 busy
`ifdef FFT16_SAT_FLAG_EN
  ,
  output logic                 sat_flag
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and data holds while valid && !ready.

  state_t                      state;
  logic [$clog2(N)-1:0]        cnt;
  logic signed [DW-1:0]        mem_re [N];
  logic signed [DW-1:0]        mem_im [N];
  logic [3:0]                  idx [RAD];
  logic [4*DW-1:0]             bf_in_re, bf_in_im, bf_out_re, bf_out_im;
  logic signed [DW-1:0]        tw_re [1:3];
  logic signed [DW-1:0]        tw_im [1:3];
  logic signed [DW-1:0]        cm_re [1:3];
  logic signed [DW-1:0]        cm_im [1:3];
  logic signed [DW-1:0]        res_re [RAD];
  logic signed [DW-1:0]        res_im [RAD];
  logic [3:0]                  out_idx;
`ifdef FFT16_SAT_FLAG_EN
  logic [3:1]                  cm_sat;
`endif

  // Stage 0 touches a stride-4 column, stage 1 a contiguous row; the write set
  // equals the read set, so results go straight back in place.
  always_comb begin
    for (int j = 0; j < RAD; j++) begin
      idx[j] = (state == STAGE1) ? {cnt[1:0], 2'(j)} : {2'(j), cnt[1:0]};
      bf_in_re[DW*j +: DW] = mem_re[idx[j]];
      bf_in_im[DW*j +: DW] = mem_im[idx[j]];
    end
  end

  r4_bfly u_bfly (
    .x_re (bf_in_re),
    .x_im (bf_in_im),
    .y_re (bf_out_re),
    .y_im (bf_out_im)
  );

  for (genvar k = 1; k < RAD; k++) begin : g_tw
    assign {tw_re[k], tw_im[k]} = twiddle(tw_index(cnt[1:0], 2'(k)));
    cmul_q15 #(.FRAC(TW_FRAC)) u_cmul (
      .xr  (bf_out_re[DW*k +: DW]),
      .xi  (bf_out_im[DW*k +: DW]),
      .wr  (tw_re[k]),
      .wi  (tw_im[k]),
      .yr  (cm_re[k]),
      .yi  (cm_im[k]),
`ifdef FFT16_SAT_FLAG_EN
      .sat (cm_sat[k])
`else
      .sat ()
`endif
    );
  end

  always_comb begin
    res_re[0] = bf_out_re[DW-1:0];
    res_im[0] = bf_out_im[DW-1:0];
    for (int j = 1; j < RAD; j++) begin
      res_re[j] = (state == STAGE0) ? cm_re[j] : bf_out_re[DW*j +: DW];
      res_im[j] = (state == STAGE0) ? cm_im[j] : bf_out_im[DW*j +: DW];
    end
  end

  // X[k] lives at 4*(k%4) + k/4 after stage 1.
  assign out_idx  = {cnt[1:0], cnt[3:2]};
  assign out_real = mem_re[out_idx];
  assign out_imag = mem_im[out_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          if (in_valid && in_ready) begin
            mem_re[cnt] <= in_real;
            mem_im[cnt] <= in_imag;
            cnt         <= cnt + 4'd1;
            if (cnt == 4'(N - 1)) begin
              state    <= STAGE0;
              in_ready <= 1'b0;
              busy     <= 1'b1;
            end
          end
        end
        STAGE0, STAGE1: begin
          for (int j = 0; j < RAD; j++) begin
            mem_re[idx[j]] <= res_re[j];
            mem_im[idx[j]] <= res_im[j];
          end
          cnt <= cnt + 4'd1;
          if (cnt == 4'(RAD - 1)) begin
            cnt <= '0;
            if (state == STAGE0) begin
              state <= STAGE1;
            end else begin
              state     <= UNLOAD;
              out_valid <= 1'b1;
              out_last  <= 1'b0;
            end
          end
        end
        UNLOAD: begin
          if (out_valid && out_ready) begin
            cnt      <= cnt + 4'd1;
            out_last <= (cnt == 4'(N - 2));
            if (cnt == 4'(N - 1)) begin
              state     <= LOAD;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              in_ready  <= 1'b1;
              busy      <= 1'b0;
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

`ifdef FFT16_SAT_FLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_flag <= 1'b0;
    end else if (state == LOAD && in_valid && in_ready && cnt == '0) begin
      sat_flag <= 1'b0;
    end else if (state == STAGE0 && |cm_sat) begin
      sat_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fft16_r4_seq.sv
// Directed bench for fft16_r4_seq: impulse, DC, shifted impulse, backpressure,
// clamping and mid-frame reset, with hand-computed spectra.
module tb_fft16_r4_seq;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_real, in_imag;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_real, out_imag;
  logic               out_last;
  logic               busy;
`ifdef FFT16_SAT_FLAG_EN
  logic               sat_flag;
`endif

  always #5 clk = ~clk;

  fft16_r4_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_real   (in_real),
    .in_imag   (in_imag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_real  (out_real),
    .out_imag  (out_imag),
    .out_last  (out_last),
    .busy      (busy)
`ifdef FFT16_SAT_FLAG_EN
    ,
    .sat_flag  (sat_flag)
`endif
  );

  int                 n_vec = 0;
  int                 n_bad = 0;
  logic [31:0]        exp_q[$];
  logic [31:0]        got [16];
  logic signed [15:0] x_re [16];
  logic signed [15:0] x_im [16];

  // x[1] = 16384 gives X[k] ~ 4096 * W16^k; values follow the fixed-point path.
  int sh_re [16] = '{4096, 3784, 2896, 1567, 0, -1568, -2896, -3784,
                     -4096, -3785, -2897, -1568, 0, 1567, 2896, 3784};
  int sh_im [16] = '{0, -1568, -2896, -3784, -4096, -3785, -2897, -1568,
                     0, 1567, 2896, 3784, 4096, 3784, 2896, 1567};

  function automatic logic [31:0] pk(int re, int im);
    return {16'(re), 16'(im)};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_x();
    for (int i = 0; i < 16; i++) begin
      x_re[i] = '0;
      x_im[i] = '0;
    end
  endtask

  task automatic push_impulse_exp();
    for (int i = 0; i < 16; i++) exp_q.push_back(pk(4096, 0));
  endtask

  // Called at a negedge; returns at the negedge right after the 16th handshake.
  task automatic send_frame();
    for (int i = 0; i < 16; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_real  = x_re[i];
      in_imag  = x_im[i];
      while (!in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) begin
        check("in_ready_timeout", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // Junk is offered on the input side while computing; it must be ignored.
  task automatic wait_out();
    int lat = 1;
    bit ready_seen = 1'b0;
    bit idle_seen  = 1'b0;
    in_valid = 1'b1;
    in_real  = 16'sh1234;
    in_imag  = -16'sh0777;
    while (!out_valid && lat < 40) begin
      if (in_ready) ready_seen = 1'b1;
      if (!busy)    idle_seen  = 1'b1;
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 32'(lat), 32'd9);
    check("in_ready_low", 32'(ready_seen), 32'd0);
    check("busy_high", 32'(idle_seen), 32'd0);
  endtask

  task automatic collect_frame(input bit bp);
    int k = 0;
    int cyc = 0;
    bit stalled = 1'b0;
    bit rdy_bad = 1'b0;
    logic [31:0] held = '0;
    while (k < 16 && cyc < 600) begin
      out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      if (out_valid) begin
        if (in_ready) rdy_bad = 1'b1;
        if (stalled) check($sformatf("stall_hold k%0d", k), {out_real, out_imag}, held);
        if (out_ready) begin
          got[k] = {out_real, out_imag};
          check($sformatf("out_last k%0d", k), 32'(out_last), 32'(k == 15));
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = {out_real, out_imag};
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b0;
    check("frame_len", 32'(k), 32'd16);
    check("no_overlap", 32'(rdy_bad), 32'd0);
    check("valid_drop", 32'(out_valid), 32'd0);
    check("ready_back", 32'(in_ready), 32'd1);
  endtask

  task automatic score_frame(input string tag);
    for (int k = 0; k < 16; k++) begin
      if (exp_q.size() == 0) begin
        check({tag, " exp_empty"}, 32'd0, 32'd1);
        return;
      end
      check($sformatf("%s X[%0d]", tag, k), got[k], exp_q.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_real   = '0;
    in_imag   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst in_ready", 32'(in_ready), 32'd1);
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst out_last", 32'(out_last), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
`ifdef FFT16_SAT_FLAG_EN
    check("rst sat_flag", 32'(sat_flag), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    // Impulse at n=0
    clear_x();
    x_re[0] = 16'sd16384;
    push_impulse_exp();
    send_frame(); wait_out(); collect_frame(1'b0); score_frame("imp");

    // DC
    for (int i = 0; i < 16; i++) begin
      x_re[i] = 16'sd4000;
      x_im[i] = '0;
    end
    exp_q.push_back(pk(16000, 0));
    for (int i = 1; i < 16; i++) exp_q.push_back(pk(0, 0));
    repeat ($urandom_range(0, 3)) @(negedge clk);
    send_frame(); wait_out(); collect_frame(1'b0); score_frame("dc");
`ifdef FFT16_SAT_FLAG_EN
    check("dc sat_flag", 32'(sat_flag), 32'd0);
`endif

    // Impulse at n=1 exercises every twiddle
    clear_x();
    x_re[1] = 16'sd16384;
    for (int i = 0; i < 16; i++) exp_q.push_back(pk(sh_re[i], sh_im[i]));
    send_frame(); wait_out(); collect_frame(1'b0); score_frame("shift");

    // Clamping frame: group n0=2, k1=1 real part saturates to -32768
    clear_x();
    x_re[2] = -16'sd32768; x_im[2] = -16'sd32768;
    x_re[6] = 16'sd32767;  x_im[6] = -16'sd32768;
    send_frame(); wait_out(); collect_frame(1'b0);
    check("sat X[0]", got[0], pk(-1, -16384));
    check("sat X[4]", got[4], pk(0, 16384));
    check("sat X[1]", got[1], pk(-16384, 0));
    check("sat X[5]", got[5], pk(16384, 0));
`ifdef FFT16_SAT_FLAG_EN
    check("sat_flag set", 32'(sat_flag), 32'd1);
    repeat (3) @(negedge clk);
    check("sat_flag held", 32'(sat_flag), 32'd1);
`endif

    // Impulse under 1,0,0,1 backpressure
    clear_x();
    x_re[0] = 16'sd16384;
    push_impulse_exp();
    send_frame();
`ifdef FFT16_SAT_FLAG_EN
    check("sat_flag cleared", 32'(sat_flag), 32'd0);
`endif
    wait_out(); collect_frame(1'b1); score_frame("bp");

    // Reset after 5 outputs of a frame
    send_frame(); wait_out();
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    check("mid out_valid", 32'(out_valid), 32'd1);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    check("rst2 out_valid", 32'(out_valid), 32'd0);
    check("rst2 in_ready", 32'(in_ready), 32'd1);
    check("rst2 busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    push_impulse_exp();
    send_frame(); wait_out(); collect_frame(1'b0); score_frame("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
